// File: rtl/usb_fs_out_ctrl.sv
// USB full-speed OUT/SETUP transaction controller: token decode, CRC16 stripping,
// per-endpoint data toggle tracking and ACK/NAK handshake request generation.
module usb_fs_out_ctrl #(
    parameter int TIMEOUT_CYCLES = 192,
    parameter int MAX_PAYLOAD    = 64
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic [6:0] dev_addr,
    input  logic       rx_pkt_start,
    input  logic       rx_pkt_end,
    input  logic [3:0] rx_pid,
    input  logic [6:0] rx_addr,
    input  logic [3:0] rx_endp,
    input  logic       rx_valid_packet,
    input  logic       rx_data_put,
    input  logic [7:0] rx_data,
    input  logic [3:0] ep_req,
    input  logic [3:0] toggle_clr,
    output logic [3:0] ep_grant,
    output logic       ep_setup,
    output logic       ep_data_put,
    output logic [7:0] ep_data,
    output logic       ep_commit,
    output logic       ep_abort,
    output logic       tx_hs_req,
    output logic [3:0] tx_hs_pid,
    input  logic       tx_hs_ack,
    output logic [3:0] ep_toggle
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam int                WAIT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]        BABBLE_LIMIT = 9'(MAX_PAYLOAD + 2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        RX_DATA   = 2'd2,
        HS_WAIT   = 2'd3
    } state_t;

    state_t            state_r;
    logic [1:0]        endp_r;
    logic              nak_r;
    logic              babble_r;
    logic              grant_drop_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [7:0]        byte_cnt_r;
    logic [1:0]        held_r;
    logic [7:0]        dly0_r;
    logic [7:0]        dly1_r;

    logic              tok_s;
    logic              data_pid_s;
    logic              commit_s;
    logic [7:0]        byte_cnt_inc_s;
    logic              over_s;
    logic [3:0]        toggle_next_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Token/data decode, byte-count saturation and next data-toggle vector.
    always_comb begin
        data_pid_s = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
        tok_s      = (state_r != HS_WAIT) && rx_pkt_end && rx_valid_packet &&
                     ((rx_pid == PID_OUT) || (rx_pid == PID_SETUP)) &&
                     (rx_addr == dev_addr) && (rx_endp[3:2] == 2'b00);
        commit_s   = (state_r == RX_DATA) && rx_pkt_end && !tok_s && rx_valid_packet &&
                     !babble_r && data_pid_s && !nak_r && (rx_pid[3] == ep_toggle[endp_r]);
        if (byte_cnt_r == 8'd255) begin
            byte_cnt_inc_s = 8'd255;
        end else begin
            byte_cnt_inc_s = byte_cnt_r + 8'd1;
        end
        over_s = {1'b0, byte_cnt_inc_s} > BABBLE_LIMIT;
        toggle_next_s = ep_toggle;
        if (tok_s && (rx_pid == PID_SETUP)) begin
            toggle_next_s[rx_endp[1:0]] = 1'b0;
        end else if (commit_s) begin
            toggle_next_s[endp_r] = ~ep_toggle[endp_r];
        end else begin
            toggle_next_s = ep_toggle;
        end
        // An explicit clear beats any same-cycle toggle update.
        toggle_next_s = toggle_next_s & ~toggle_clr;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            endp_r       <= 2'd0;
            nak_r        <= 1'b0;
            babble_r     <= 1'b0;
            grant_drop_r <= 1'b0;
            wait_cnt_r   <= '0;
            byte_cnt_r   <= 8'd0;
            held_r       <= 2'd0;
            dly0_r       <= 8'd0;
            dly1_r       <= 8'd0;
            ep_grant     <= 4'd0;
            ep_setup     <= 1'b0;
            ep_data_put  <= 1'b0;
            ep_data      <= 8'd0;
            ep_commit    <= 1'b0;
            ep_abort     <= 1'b0;
            tx_hs_req    <= 1'b0;
            tx_hs_pid    <= 4'd0;
            ep_toggle    <= 4'd0;
        end else begin
            ep_commit   <= 1'b0;
            ep_abort    <= 1'b0;
            ep_data_put <= 1'b0;
            ep_toggle   <= toggle_next_s;
            // Grant stays up through the commit/abort cycle and drops one cycle later.
            if (grant_drop_r) begin
                ep_grant     <= 4'd0;
                ep_setup     <= 1'b0;
                grant_drop_r <= 1'b0;
            end
            if (tok_s) begin
                state_r      <= WAIT_DATA;
                endp_r       <= rx_endp[1:0];
                ep_setup     <= (rx_pid == PID_SETUP);
                nak_r        <= ~ep_req[rx_endp[1:0]];
                ep_grant     <= onehot4(rx_endp[1:0]);
                wait_cnt_r   <= '0;
                grant_drop_r <= 1'b0;
                ep_abort     <= (state_r == WAIT_DATA) || (state_r == RX_DATA);
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    WAIT_DATA: begin
                        if (rx_pkt_start) begin
                            state_r    <= RX_DATA;
                            byte_cnt_r <= 8'd0;
                            held_r     <= 2'd0;
                            babble_r   <= 1'b0;
                        end else if (wait_cnt_r == WAIT_LAST) begin
                            state_r      <= IDLE;
                            ep_abort     <= 1'b1;
                            grant_drop_r <= 1'b1;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (rx_pkt_end) begin
                            grant_drop_r <= 1'b1;
                            if (!rx_valid_packet || babble_r || !data_pid_s) begin
                                state_r  <= IDLE;
                                ep_abort <= 1'b1;
                            end else if (nak_r) begin
                                state_r   <= HS_WAIT;
                                ep_abort  <= 1'b1;
                                tx_hs_req <= 1'b1;
                                tx_hs_pid <= PID_NAK;
                            end else if (!commit_s) begin
                                state_r   <= HS_WAIT;
                                ep_abort  <= 1'b1;
                                tx_hs_req <= 1'b1;
                                tx_hs_pid <= PID_ACK;
                            end else begin
                                state_r   <= HS_WAIT;
                                ep_commit <= 1'b1;
                                tx_hs_req <= 1'b1;
                                tx_hs_pid <= PID_ACK;
                            end
                        end else if (rx_data_put) begin
                            // Two-byte delay line keeps the trailing CRC16 away from the endpoint.
                            dly0_r     <= rx_data;
                            dly1_r     <= dly0_r;
                            byte_cnt_r <= byte_cnt_inc_s;
                            if (held_r != 2'd2) begin
                                held_r <= held_r + 2'd1;
                            end
                            if (over_s) begin
                                babble_r <= 1'b1;
                            end
                            if ((held_r == 2'd2) && !nak_r && !over_s) begin
                                ep_data_put <= 1'b1;
                                ep_data     <= dly1_r;
                            end
                        end
                    end
                    HS_WAIT: begin
                        if (tx_hs_ack) begin
                            state_r   <= IDLE;
                            tx_hs_req <= 1'b0;
                            tx_hs_pid <= 4'd0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_fs_out_ctrl.sv
// Randomized scoreboard bench for usb_fs_out_ctrl: a transaction-level model
// queues expected endpoint/handshake events that a monitor checks as they appear.
module tb_usb_fs_out_ctrl;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam int         MAXP      = 64;
    localparam int         TMO       = 192;

    localparam logic [1:0] EV_DATA   = 2'd0;
    localparam logic [1:0] EV_COMMIT = 2'd1;
    localparam logic [1:0] EV_ABORT  = 2'd2;
    localparam logic [1:0] EV_HS     = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] val;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic [6:0] dev_addr;
    logic       rx_pkt_start, rx_pkt_end, rx_valid_packet, rx_data_put;
    logic [3:0] rx_pid, rx_endp, ep_req, toggle_clr;
    logic [6:0] rx_addr;
    logic [7:0] rx_data;
    logic [3:0] ep_grant, tx_hs_pid, ep_toggle;
    logic       ep_setup, ep_data_put, ep_commit, ep_abort, tx_hs_req, tx_hs_ack;
    logic [7:0] ep_data;

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] mdl_tog = 4'd0;
    ev_t        exp_q[$];
    logic [7:0] payload[$];
    logic       hs_prev = 1'b0;
    logic [3:0] hs_pid_prev = 4'd0;

    usb_fs_out_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_PAYLOAD(MAXP)) dut (
        .clk_48mhz(clk), .reset_n(reset_n), .dev_addr(dev_addr),
        .rx_pkt_start(rx_pkt_start), .rx_pkt_end(rx_pkt_end), .rx_pid(rx_pid),
        .rx_addr(rx_addr), .rx_endp(rx_endp), .rx_valid_packet(rx_valid_packet),
        .rx_data_put(rx_data_put), .rx_data(rx_data), .ep_req(ep_req),
        .toggle_clr(toggle_clr), .ep_grant(ep_grant), .ep_setup(ep_setup),
        .ep_data_put(ep_data_put), .ep_data(ep_data), .ep_commit(ep_commit),
        .ep_abort(ep_abort), .tx_hs_req(tx_hs_req), .tx_hs_pid(tx_hs_pid),
        .tx_hs_ack(tx_hs_ack), .ep_toggle(ep_toggle)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [7:0] val);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d value %0h expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.val !== val) begin
                miscompares++;
                $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every visible output event is popped against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            if (ep_data_put) check_ev(EV_DATA, ep_data);
            if (ep_commit)   check_ev(EV_COMMIT, {4'd0, ep_grant});
            if (ep_abort)    check_ev(EV_ABORT, {4'd0, ep_grant});
            if (tx_hs_req && !hs_prev) check_ev(EV_HS, {4'd0, tx_hs_pid});
            else if (tx_hs_req) check("hs_pid_stable", {28'd0, tx_hs_pid}, {28'd0, hs_pid_prev});
            hs_prev     = tx_hs_req;
            hs_pid_prev = tx_hs_pid;
        end
    end

    // Transmitter stand-in: acknowledges a handshake request after a random delay.
    initial begin
        tx_hs_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_hs_req) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                tx_hs_ack = 1'b1;
                @(negedge clk);
                tx_hs_ack = 1'b0;
            end
        end
    end

    task automatic send_token(input logic [3:0] pid, input logic [6:0] addr,
                              input logic [3:0] endp, input logic valid);
        tick;
        rx_pkt_start = 1'b1;
        tick;
        rx_pkt_start = 1'b0;
        tick;
        rx_pid = pid; rx_addr = addr; rx_endp = endp; rx_valid_packet = valid;
        rx_pkt_end = 1'b1;
        tick;
        rx_pkt_end = 1'b0; rx_valid_packet = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] dpid, input logic valid, input int n,
                             input logic [3:0] clr);
        tick;
        rx_pkt_start = 1'b1;
        tick;
        rx_pkt_start = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            rx_data_put = 1'b1;
            rx_data = (i < n) ? payload[i] : 8'($urandom);
            tick;
            rx_data_put = 1'b0;
            if ($urandom_range(0, 3) == 0) tick;
        end
        rx_pid = dpid; rx_valid_packet = valid; rx_pkt_end = 1'b1; toggle_clr = clr;
        tick;
        rx_pkt_end = 1'b0; rx_valid_packet = 1'b0; toggle_clr = 4'd0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        repeat (2) tick;
        while (tx_hs_req && n < 30) begin
            tick;
            n++;
        end
        check("hs_released", {31'd0, tx_hs_req}, 32'd0);
        repeat (2) tick;
    endtask

    // Reference: what one OUT/SETUP + DATA transaction should produce.
    task automatic model_txn(input logic [3:0] tok, input int endp, input logic req_bit,
                             input logic [3:0] dpid, input int n, input logic crc_ok,
                             input logic [3:0] clr);
        logic [7:0] g;
        g = {4'd0, 4'b0001 << endp};
        if (tok == PID_SETUP) mdl_tog[endp] = 1'b0;
        if (req_bit) begin
            for (int i = 0; i < n && i < MAXP; i++) push_ev(EV_DATA, payload[i]);
        end
        if (!crc_ok || n > MAXP) begin
            push_ev(EV_ABORT, g);
        end else if (!req_bit) begin
            push_ev(EV_ABORT, g);
            push_ev(EV_HS, {4'd0, PID_NAK});
        end else if (dpid[3] != mdl_tog[endp]) begin
            push_ev(EV_ABORT, g);
            push_ev(EV_HS, {4'd0, PID_ACK});
        end else begin
            push_ev(EV_COMMIT, g);
            push_ev(EV_HS, {4'd0, PID_ACK});
            mdl_tog[endp] = ~mdl_tog[endp];
        end
        mdl_tog = mdl_tog & ~clr;
    endtask

    task automatic run_txn(input logic [3:0] tok, input int endp, input logic req_bit,
                           input logic [3:0] dpid, input int n, input logic crc_ok,
                           input logic [3:0] clr);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
        ep_req = 4'($urandom);
        ep_req[endp] = req_bit;
        model_txn(tok, endp, req_bit, dpid, n, crc_ok, clr);
        send_token(tok, 7'd5, 4'(endp), 1'b1);
        check("grant_on_token", {28'd0, ep_grant}, {28'd0, 4'b0001 << endp});
        check("setup_flag", {31'd0, ep_setup}, {31'd0, tok == PID_SETUP});
        repeat ($urandom_range(1, 4)) tick;
        send_data(dpid, crc_ok, n, clr);
        wait_idle;
        check("toggle", {28'd0, ep_toggle}, {28'd0, mdl_tog});
        check("grant_released", {28'd0, ep_grant}, 32'd0);
    endtask

    task automatic bad_token;
        int k;
        k = $urandom_range(0, 2);
        case (k)
            0:       send_token(PID_OUT, 7'd5 ^ 7'($urandom_range(1, 127)), 4'd1, 1'b1);
            1:       send_token(PID_SETUP, 7'd5, 4'($urandom_range(4, 15)), 1'b1);
            default: send_token(PID_OUT, 7'd5, 4'd2, 1'b0);
        endcase
        repeat (3) tick;
        check("ignored_token_grant", {28'd0, ep_grant}, 32'd0);
    endtask

    task automatic measure_timeout(input string name);
        int c;
        c = 0;
        do begin
            tick;
            c++;
        end while (!ep_abort && c < 400);
        check(name, c, TMO);
        tick;
        check({name, "_grant"}, {28'd0, ep_grant}, 32'd0);
    endtask

    initial begin
        logic [3:0] tok, dpid, clr;
        logic       ebit, dbit;
        int         e, n;
        reset_n = 1'b0; dev_addr = 7'd5;
        rx_pkt_start = 1'b0; rx_pkt_end = 1'b0; rx_valid_packet = 1'b0; rx_data_put = 1'b0;
        rx_pid = 4'd0; rx_addr = 7'd0; rx_endp = 4'd0; rx_data = 8'd0;
        ep_req = 4'd0; toggle_clr = 4'd0;
        #5;
        check("reset_outputs", {7'd0, ep_grant, ep_setup, ep_data_put, ep_data, ep_commit,
              ep_abort, tx_hs_req, tx_hs_pid, ep_toggle}, 32'd0);
        repeat (3) tick;
        reset_n = 1'b1;
        tick;

        run_txn(PID_SETUP, 0, 1'b1, PID_DATA0, 8, 1'b1, 4'd0);    // setup, 8 bytes, ACK
        run_txn(PID_OUT,   2, 1'b0, PID_DATA0, 4, 1'b1, 4'd0);    // endpoint busy: NAK
        run_txn(PID_OUT,   1, 1'b1, PID_DATA0, 3, 1'b1, 4'd0);    // toggle 1 on ep1
        run_txn(PID_OUT,   1, 1'b1, PID_DATA0, 5, 1'b1, 4'd0);    // stale toggle
        run_txn(PID_OUT,   1, 1'b1, PID_DATA0, 4, 1'b0, 4'd0);    // bad CRC
        run_txn(PID_OUT,   3, 1'b1, PID_DATA1, 70, 1'b1, 4'd0);   // babble
        run_txn(PID_OUT,   2, 1'b1, PID_DATA0, 64, 1'b1, 4'd0);   // exactly max payload
        run_txn(PID_SETUP, 0, 1'b1, PID_DATA0, 4, 1'b1, 4'b0001); // clear beats commit flip
        run_txn(PID_OUT,   3, 1'b1, PID_DATA0, 0, 1'b1, 4'd0);    // zero-length

        ep_req = 4'b1111;
        push_ev(EV_ABORT, 8'h01);
        send_token(PID_OUT, 7'd5, 4'd0, 1'b1);
        measure_timeout("timeout_cycle");

        push_ev(EV_ABORT, 8'h08);
        push_ev(EV_ABORT, 8'h08);
        send_token(PID_OUT, 7'd5, 4'd0, 1'b1);
        repeat (95) tick;
        send_token(PID_OUT, 7'd5, 4'd3, 1'b1);
        check("restart_grant", {28'd0, ep_grant}, 32'h8);
        measure_timeout("restart_timeout_cycle");

        payload.delete();
        for (int i = 0; i < 10; i++) payload.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) push_ev(EV_DATA, payload[i]);
        send_token(PID_OUT, 7'd5, 4'd1, 1'b1);
        repeat (2) tick;
        rx_pkt_start = 1'b1;
        tick;
        rx_pkt_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rx_data_put = 1'b1; rx_data = payload[i];
            tick;
            rx_data_put = 1'b0;
        end
        tick;
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {7'd0, ep_grant, ep_setup, ep_data_put, ep_data, ep_commit,
              ep_abort, tx_hs_req, tx_hs_pid, ep_toggle}, 32'd0);
        check("bytes_before_reset", exp_q.size(), 32'd0);
        exp_q.delete();
        mdl_tog = 4'd0;
        repeat (2) tick;
        reset_n = 1'b1;
        for (int i = 6; i < 12; i++) begin
            rx_data_put = 1'b1; rx_data = 8'($urandom);
            tick;
            rx_data_put = 1'b0;
        end
        rx_pid = PID_DATA0; rx_valid_packet = 1'b1; rx_pkt_end = 1'b1;
        tick;
        rx_pkt_end = 1'b0; rx_valid_packet = 1'b0;
        wait_idle;
        check("toggle_after_reset", {28'd0, ep_toggle}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) bad_token;
            tok = ($urandom_range(0, 2) == 0) ? PID_SETUP : PID_OUT;
            e = $urandom_range(0, 3);
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 72) : $urandom_range(0, 16);
            ebit = (tok == PID_SETUP) ? 1'b0 : mdl_tog[e];
            dbit = ($urandom_range(0, 3) == 0) ? ~ebit : ebit;
            dpid = dbit ? PID_DATA1 : PID_DATA0;
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            run_txn(tok, e, $urandom_range(0, 4) != 0, dpid, n, $urandom_range(0, 7) != 0, clr);
        end

        repeat (5) tick;
        check("events_outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
